step_phase_decoder: RTL and testbench

Monitors the 4-bit full-step coil pattern driven toward the PmodSTEP and reconstructs motor motion from it.
- Outputs signed step position, last direction, per-step pulse, motion status and sequence-fault flags.
- Sits beside the stepper driver, tapping its coil outputs, so the rest of the design gets closed-loop position knowledge and the limit/home switch can zero the count.

---
 rtl/step_phase_decoder.sv | 190 +++++++++++++++++++
 tb/tb_step_phase_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/step_phase_decoder.sv
// Tracks a full-step coil pattern and reconstructs signed position, direction,
// motion status and sequence faults from the filtered phase sequence.
module step_phase_decoder #(
    parameter int POS_W         = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int IDLE_TIMEOUT  = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       signal_in,
    input  logic             home,
    input  logic             clear_err,
    output logic [POS_W-1:0] position,
    output logic             dir,
    output logic             step_pulse,
    output logic             moving,
    output logic             coils_off,
    output logic             skip_err,
    output logic             pattern_err
);
    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_TIMEOUT);

    typedef enum logic [0:0] {NO_REF = 1'b0, TRACK = 1'b1} state_t;

    // Returns {legal, phase index}; index order P0..P3 is forward rotation.
    function automatic logic [2:0] phase_of(input logic [3:0] pat);
        case (pat)
            4'b1100: phase_of = 3'b100;
            4'b0110: phase_of = 3'b101;
            4'b0011: phase_of = 3'b110;
            4'b1001: phase_of = 3'b111;
            default: phase_of = 3'b000;
        endcase
    endfunction

    logic [3:0]        sig_meta_r, sig_sync_r, prev_r, last_acc_r;
    logic              home_meta_r, home_sync_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDLE_W-1:0] idle_r;
    logic [1:0]        ref_r, ref_d, delta_s;
    logic [2:0]        ph_s;
    logic              accept_s, fwd_s, rev_s, skip_s, perr_s, coils_set_s, coils_clr_s;
    state_t            state_r, state_d;

    assign ph_s     = phase_of(sig_sync_r);
    assign delta_s  = ph_s[1:0] - ref_r;
    // A pattern already accepted is not re-accepted, so a glitch back to it is silent.
    assign accept_s = (sig_sync_r == prev_r) && (cnt_r == CNT_LAST) && (sig_sync_r != last_acc_r);

    // Input synchronizers and stability filter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_meta_r  <= 4'b0000;
            sig_sync_r  <= 4'b0000;
            home_meta_r <= 1'b0;
            home_sync_r <= 1'b0;
            prev_r      <= 4'b0000;
            last_acc_r  <= 4'b0000;
            cnt_r       <= '0;
        end else begin
            sig_meta_r  <= signal_in;
            sig_sync_r  <= sig_meta_r;
            home_meta_r <= home;
            home_sync_r <= home_meta_r;
            prev_r      <= sig_sync_r;
            if (sig_sync_r != prev_r) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (accept_s) begin
                last_acc_r <= sig_sync_r;
            end
        end
    end

    // FSM state and phase reference
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= NO_REF;
            ref_r   <= 2'd0;
        end else begin
            state_r <= state_d;
            ref_r   <= ref_d;
        end
    end

    // Classify each accepted pattern against the reference
    always_comb begin
        state_d     = state_r;
        ref_d       = ref_r;
        fwd_s       = 1'b0;
        rev_s       = 1'b0;
        skip_s      = 1'b0;
        perr_s      = 1'b0;
        coils_set_s = 1'b0;
        coils_clr_s = 1'b0;
        if (accept_s) begin
            if (sig_sync_r == 4'b0000) begin
                coils_set_s = 1'b1;
            end else if (!ph_s[2]) begin
                coils_clr_s = 1'b1;
                perr_s      = 1'b1;
            end else begin
                coils_clr_s = 1'b1;
                case (state_r)
                    NO_REF: begin
                        ref_d   = ph_s[1:0];
                        state_d = TRACK;
                    end
                    TRACK: begin
                        ref_d = ph_s[1:0];
                        case (delta_s)
                            2'd1:    fwd_s  = 1'b1;
                            2'd3:    rev_s  = 1'b1;
                            2'd2:    skip_s = 1'b1;
                            default: ref_d  = ref_r;
                        endcase
                    end
                    default: state_d = NO_REF;
                endcase
            end
        end else begin
            state_d = state_r;
        end
    end

    // Position, direction, pulse and coil status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            position   <= '0;
            dir        <= 1'b1;
            step_pulse <= 1'b0;
            coils_off  <= 1'b1;
        end else begin
            step_pulse <= fwd_s | rev_s;
            if (home_sync_r) begin
                position <= '0;
            end else if (fwd_s) begin
                position <= position + POS_W'(1);
            end else if (rev_s) begin
                position <= position - POS_W'(1);
            end
            if (fwd_s) begin
                dir <= 1'b1;
            end else if (rev_s) begin
                dir <= 1'b0;
            end
            if (coils_set_s) begin
                coils_off <= 1'b1;
            end else if (coils_clr_s) begin
                coils_off <= 1'b0;
            end
        end
    end

    // Motion timeout and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_r      <= '0;
            moving      <= 1'b0;
            skip_err    <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            if (fwd_s || rev_s) begin
                idle_r <= IDLE_LOAD;
                moving <= 1'b1;
            end else if (idle_r != '0) begin
                idle_r <= idle_r - IDLE_W'(1);
                if (idle_r == IDLE_W'(1)) begin
                    moving <= 1'b0;
                end
            end
            if (skip_s) begin
                skip_err <= 1'b1;
            end else if (clear_err) begin
                skip_err <= 1'b0;
            end
            if (perr_s) begin
                pattern_err <= 1'b1;
            end else if (clear_err) begin
                pattern_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_step_phase_decoder.sv
// Directed, table-driven bench for step_phase_decoder (POS_W=4 to reach the wrap quickly).
module tb_step_phase_decoder;
    localparam int POS_W = 4;
    localparam int STABLE = 4;
    localparam int IDLE = 20;
    localparam int LAT = STABLE + 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       signal_in = 4'b0000;
    logic             home = 1'b0;
    logic             clear_err = 1'b0;
    logic [POS_W-1:0] position;
    logic             dir, step_pulse, moving, coils_off, skip_err, pattern_err;

    int total_cnt = 0;
    int pass_cnt = 0;

    step_phase_decoder #(.POS_W(POS_W), .STABLE_CYCLES(STABLE), .IDLE_TIMEOUT(IDLE)) dut (
        .clk(clk), .rst(rst), .signal_in(signal_in), .home(home), .clear_err(clear_err),
        .position(position), .dir(dir), .step_pulse(step_pulse), .moving(moving),
        .coils_off(coils_off), .skip_err(skip_err), .pattern_err(pattern_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pat;
        int         hold;
        logic       hm;
        logic       clr;
        int         pulses;
        logic [3:0] pos;
        logic       dir;
        logic       coils;
        logic       skip;
        logic       perr;
        logic       mov;
    } vec_t;

    vec_t vecs[33];

    function automatic vec_t mk(logic [3:0] pat, int hold, logic hm, logic clr, int pulses,
                                logic [3:0] pos, logic d, logic coils, logic skip, logic perr,
                                logic mov);
        vec_t v;
        v.pat = pat; v.hold = hold; v.hm = hm; v.clr = clr; v.pulses = pulses;
        v.pos = pos; v.dir = d; v.coils = coils; v.skip = skip; v.perr = perr; v.mov = mov;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".pos"}, 32'(position), 32'd0);
        check({tag, ".dir"}, 32'(dir), 32'd1);
        check({tag, ".pulse"}, 32'(step_pulse), 32'd0);
        check({tag, ".moving"}, 32'(moving), 32'd0);
        check({tag, ".coils"}, 32'(coils_off), 32'd1);
        check({tag, ".skip"}, 32'(skip_err), 32'd0);
        check({tag, ".perr"}, 32'(pattern_err), 32'd0);
    endtask

    // Drives one vector for v.hold cycles, sampling 1ns after every rising edge.
    task automatic apply(input vec_t v, input string tag);
        int npulse;
        int first;
        signal_in = v.pat;
        home      = v.hm;
        clear_err = v.clr;
        npulse    = 0;
        first     = -1;
        for (int i = 1; i <= v.hold; i++) begin
            @(posedge clk);
            #1;
            if (step_pulse) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
        check({tag, ".pulses"}, 32'(npulse), 32'(v.pulses));
        if (v.pulses == 1) check({tag, ".latency"}, 32'(first), 32'(LAT));
        check({tag, ".pos"}, 32'(position), 32'(v.pos));
        check({tag, ".dir"}, 32'(dir), 32'(v.dir));
        check({tag, ".coils"}, 32'(coils_off), 32'(v.coils));
        check({tag, ".skip"}, 32'(skip_err), 32'(v.skip));
        check({tag, ".perr"}, 32'(pattern_err), 32'(v.perr));
        check({tag, ".moving"}, 32'(moving), 32'(v.mov));
    endtask

    initial begin
        //             pat      hold hm clr  pul pos    dir coil skp per mov
        vecs[0]  = mk(4'b0000, 10, 1'b0, 1'b0, 0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(4'b1100, 10, 1'b0, 1'b0, 0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(4'b0110, 10, 1'b0, 1'b0, 1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[3]  = mk(4'b0011, 10, 1'b0, 1'b0, 1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[4]  = mk(4'b1001, 10, 1'b0, 1'b0, 1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[5]  = mk(4'b1100, 10, 1'b0, 1'b0, 1, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[6]  = mk(4'b1001, 10, 1'b0, 1'b0, 1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[7]  = mk(4'b0011, 10, 1'b0, 1'b0, 1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(4'b0110, 10, 1'b0, 1'b0, 1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[9]  = mk(4'b1100, 10, 1'b0, 1'b0, 1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk(4'b1001, 10, 1'b0, 1'b0, 1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[11] = mk(4'b0011, 10, 1'b0, 1'b0, 1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // glitch, skip, illegal, coils off, resume same phase with clear
        vecs[12] = mk(4'b1001,  2, 1'b0, 1'b0, 0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(4'b0011, 10, 1'b0, 1'b0, 0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(4'b1100, 10, 1'b0, 1'b0, 0, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[15] = mk(4'b1110, 10, 1'b0, 1'b0, 0, 4'hE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[16] = mk(4'b0000, 10, 1'b0, 1'b0, 0, 4'hE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[17] = mk(4'b1100, 10, 1'b0, 1'b1, 0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // forward up to the signed wrap and back
        vecs[18] = mk(4'b0110, 10, 1'b0, 1'b0, 1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[19] = mk(4'b0011, 10, 1'b0, 1'b0, 1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[20] = mk(4'b1001, 10, 1'b0, 1'b0, 1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[21] = mk(4'b1100, 10, 1'b0, 1'b0, 1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[22] = mk(4'b0110, 10, 1'b0, 1'b0, 1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[23] = mk(4'b0011, 10, 1'b0, 1'b0, 1, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[24] = mk(4'b1001, 10, 1'b0, 1'b0, 1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[25] = mk(4'b1100, 10, 1'b0, 1'b0, 1, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[26] = mk(4'b0110, 10, 1'b0, 1'b0, 1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[27] = mk(4'b0011, 10, 1'b0, 1'b0, 1, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[28] = mk(4'b0110, 10, 1'b0, 1'b0, 1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // home held over two steps, then released
        vecs[29] = mk(4'b0011, 10, 1'b1, 1'b0, 1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[30] = mk(4'b1001, 10, 1'b1, 1'b0, 1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[31] = mk(4'b1100, 10, 1'b0, 1'b0, 1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[32] = mk(4'b1010, 10, 1'b0, 1'b0, 0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("v%0d", i));

        // Pulse of vecs[11] was 3 edges ago; moving must drop exactly IDLE edges after it.
        repeat (IDLE - 4) @(posedge clk);
        #1;
        check("idle.before", 32'(moving), 32'd1);
        @(posedge clk);
        #1;
        check("idle.expire", 32'(moving), 32'd0);

        for (int i = 12; i < 33; i++) apply(vecs[i], $sformatf("v%0d", i));

        // Asynchronous reset in the middle of a pattern hold
        signal_in = 4'b0110;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        apply(mk(4'b0110, 10, 1'b0, 1'b0, 0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "rref");
        apply(mk(4'b0011, 10, 1'b0, 1'b0, 1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "rstep");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
